// File: rtl/de_seq_pkg.sv
// Shared types and sizes for the truth-table sequencer.
// Imported by the interface, the settle timer and the top.
package de_seq_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control and result bundle of the truth-table sequencer.
// master drives start/abort/responses, slave is the sequencer.
interface truth_table_sequencer_if;
  import de_seq_pkg::*;

  logic               start;
  logic               abort;
  logic               y_nand;
  logic               y_nor;
  logic [VEC_W-1:0]   abc;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CNT_W-1:0]   mismatch_count;
  logic [NUM_VEC-1:0] table_nand;
  logic [NUM_VEC-1:0] table_nor;
  logic [VEC_W-1:0]   first_fail;
  logic               fail_seen;

  modport master (
    output start, abort, y_nand, y_nor,
    input  abc, busy, done, pass, mismatch_count,
    input  table_nand, table_nor, first_fail, fail_seen
  );

  modport slave (
    input  start, abort, y_nand, y_nor,
    output abc, busy, done, pass, mismatch_count,
    output table_nand, table_nor, first_fail, fail_seen
  );

endinterface

// File: rtl/settle_timer.sv
// Settle countdown: loaded on APPLY, decremented in SETTLE.
// expire_o marks the last SETTLE cycle.
module settle_timer
  import de_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: reload, or step down while settling
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(SETTLE_CYCLES);
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks all 8 {A,B,C} vectors, samples NAND/NOR responses,
// records both truth tables and counts mismatches.
module truth_table_sequencer
  import de_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  truth_table_sequencer_if.slave  bus
);

  state_e             state_q;
  logic [VEC_W-1:0]   idx_q;
  logic [CNT_W-1:0]   mcnt_q;
  logic [CNT_W-1:0]   mcnt_d;
  logic [NUM_VEC-1:0] tnand_q;
  logic [NUM_VEC-1:0] tnor_q;
  logic [VEC_W-1:0]   ffail_q;
  logic               fseen_q;
  logic               pass_q;
  logic               expire;
  logic               miss;
  logic               active;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (state_q == S_APPLY),
    .en_i     (state_q == S_SETTLE),
    .expire_o (expire)
  );

  assign miss = bus.y_nand != bus.y_nor;

  // saturate at NUM_VEC so the count can never wrap
  assign mcnt_d =
    (miss && mcnt_q != CNT_W'(NUM_VEC)) ?
    mcnt_q + 1'b1 : mcnt_q;

  // sequencer FSM with its result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mcnt_q  <= '0;
      tnand_q <= '0;
      tnor_q  <= '0;
      ffail_q <= '0;
      fseen_q <= 1'b0;
      pass_q  <= 1'b0;
    end else if (bus.abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q <= S_APPLY;
            idx_q   <= '0;
            mcnt_q  <= '0;
            tnand_q <= '0;
            tnor_q  <= '0;
            ffail_q <= '0;
            fseen_q <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_APPLY: begin
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (expire) begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          tnand_q[idx_q] <= bus.y_nand;
          tnor_q[idx_q]  <= bus.y_nor;
          mcnt_q         <= mcnt_d;
          if (miss && !fseen_q) begin
            ffail_q <= idx_q;
            fseen_q <= 1'b1;
          end
          if (idx_q == VEC_W'(NUM_VEC - 1)) begin
            state_q <= S_DONE;
            pass_q  <= (mcnt_d == '0);
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_APPLY;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign active =
    (state_q == S_APPLY)  ||
    (state_q == S_SETTLE) ||
    (state_q == S_SAMPLE);

  assign bus.abc            = active ? idx_q : '0;
  assign bus.busy           = state_q != S_IDLE;
  assign bus.done           = state_q == S_DONE;
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mcnt_q;
  assign bus.table_nand     = tnand_q;
  assign bus.table_nor      = tnor_q;
  assign bus.first_fail     = ffail_q;
  assign bus.fail_seen      = fseen_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: response tables stand in
// for the two gate implementations; results come from a model.
module tb_truth_table_sequencer;

  localparam int S       = 2;
  localparam int EXP_LAT = 1 + 8 * (S + 2);

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [7:0] rn;
  logic [7:0] rr;

  truth_table_sequencer_if bus ();

  truth_table_sequencer #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.y_nand = rn[bus.abc];
  assign bus.y_nor  = rr[bus.abc];

  function automatic int m_count(input logic [7:0] a,
                                 input logic [7:0] b);
    return $countones(a ^ b);
  endfunction

  function automatic logic [2:0] m_first(input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] d;
    d = a ^ b;
    for (int i = 0; i < 8; i++)
      if (d[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Launch a run; optionally re-pulse start or pulse abort
  // when abc first equals the given vector. No checking here.
  task automatic run(input int restart_at, input int abort_at,
                     output int lat, output int npulse,
                     output int abort_busy);
    bit rs_done;
    bit ab_done;
    bit ab_pend;
    rs_done = 0;
    ab_done = 0;
    ab_pend = 0;
    lat = -1;
    npulse = 0;
    abort_busy = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n < EXP_LAT + 12; n++) begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (ab_pend) begin
        abort_busy = int'(bus.busy);
        ab_pend = 0;
      end
      if (bus.done) begin
        npulse++;
        if (lat < 0) lat = n;
      end
      if (!rs_done && restart_at >= 0 && bus.busy &&
          bus.abc == 3'(restart_at)) begin
        bus.start = 1'b1;
        rs_done = 1;
      end
      if (!ab_done && abort_at >= 0 && bus.busy &&
          bus.abc == 3'(abort_at)) begin
        bus.abort = 1'b1;
        ab_done = 1;
        ab_pend = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: got %b%b expected 00",
               bus.busy, bus.done);
    end
    checks++;
    if ({bus.abc, bus.pass, bus.mismatch_count, bus.first_fail,
         bus.fail_seen} !== 12'h0) begin
      errors++;
      $display("FAIL reset_results: abc=%0d pass=%b cnt=%0d ff=%0d fs=%b",
               bus.abc, bus.pass, bus.mismatch_count,
               bus.first_fail, bus.fail_seen);
    end
    checks++;
    if ({bus.table_nand, bus.table_nor} !== 16'h0) begin
      errors++;
      $display("FAIL reset_tables: got %h/%h expected 00/00",
               bus.table_nand, bus.table_nor);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full run with given response tables, checked against the model
  task automatic test_run(input string nm, input logic [7:0] a,
                          input logic [7:0] b);
    int lat, np, ab;
    rn = a;
    rr = b;
    run(-1, -1, lat, np, ab);
    checks++;
    if (lat !== EXP_LAT || np !== 1) begin
      errors++;
      $display("FAIL %s_latency: got lat=%0d pulses=%0d expected %0d/1",
               nm, lat, np, EXP_LAT);
    end
    checks++;
    if (bus.mismatch_count !== 4'(m_count(a, b))) begin
      errors++;
      $display("FAIL %s_count: got %0d expected %0d",
               nm, bus.mismatch_count, m_count(a, b));
    end
    checks++;
    if (bus.pass !== (a == b) || bus.fail_seen !== (a != b)) begin
      errors++;
      $display("FAIL %s_pass: got pass=%b fs=%b expected %b/%b",
               nm, bus.pass, bus.fail_seen, a == b, a != b);
    end
    checks++;
    if (bus.first_fail !== m_first(a, b)) begin
      errors++;
      $display("FAIL %s_first: got %0d expected %0d",
               nm, bus.first_fail, m_first(a, b));
    end
    checks++;
    if (bus.table_nand !== a || bus.table_nor !== b) begin
      errors++;
      $display("FAIL %s_tables: got %h/%h expected %h/%h",
               nm, bus.table_nand, bus.table_nor, a, b);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.abc !== 3'd0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b abc=%0d expected 0/0",
               nm, bus.busy, bus.abc);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
      test_run("random", a, b);
    end
  endtask

  task automatic test_back_to_back();
    int lat, np, ab;
    rn = 8'h96;
    rr = 8'h96;
    run(2, -1, lat, np, ab);
    checks++;
    if (lat !== EXP_LAT || np !== 1) begin
      errors++;
      $display("FAIL restart_busy: got lat=%0d pulses=%0d expected %0d/1",
               lat, np, EXP_LAT);
    end
    checks++;
    if (bus.pass !== 1'b1 || bus.table_nor !== 8'h96) begin
      errors++;
      $display("FAIL restart_result: got pass=%b nor=%h expected 1/96",
               bus.pass, bus.table_nor);
    end
  endtask

  task automatic test_hold();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.pass !== 1'b1 || bus.table_nand !== 8'h96 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold: got pass=%b nand=%h done=%b expected 1/96/0",
               bus.pass, bus.table_nand, bus.done);
    end
  endtask

  task automatic test_abort();
    int lat, np, ab;
    logic [7:0] mask;
    mask = 8'h07;
    rn = 8'hFF;
    rr = 8'hFD;
    run(-1, 3, lat, np, ab);
    checks++;
    if (ab !== 0 || np !== 0) begin
      errors++;
      $display("FAIL abort_stop: got busy=%0d pulses=%0d expected 0/0",
               ab, np);
    end
    checks++;
    if (bus.table_nand !== (rn & mask) ||
        bus.table_nor !== (rr & mask)) begin
      errors++;
      $display("FAIL abort_tables: got %h/%h expected %h/%h",
               bus.table_nand, bus.table_nor, rn & mask, rr & mask);
    end
    checks++;
    if (bus.pass !== 1'b0 ||
        bus.mismatch_count !== 4'(m_count(rn & mask, rr & mask)) ||
        bus.first_fail !== m_first(rn, rr) || bus.fail_seen !== 1'b1) begin
      errors++;
      $display("FAIL abort_partial: got pass=%b cnt=%0d ff=%0d fs=%b expected 0/1/1/1",
               bus.pass, bus.mismatch_count, bus.first_fail,
               bus.fail_seen);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mismatch_count !== 4'd1) begin
      errors++;
      $display("FAIL start_abort_idle: got busy=%b cnt=%0d expected 0/1",
               bus.busy, bus.mismatch_count);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, np, ab;
    int k;
    rn = 8'hFF;
    rr = 8'h0F;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (bus.abc !== 3'd4 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= 60) begin
      errors++;
      $display("FAIL midrun_reach: got abc=%0d expected 4", bus.abc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({bus.abc, bus.busy, bus.done, bus.pass, bus.mismatch_count,
         bus.table_nand, bus.table_nor, bus.first_fail,
         bus.fail_seen} !== 31'h0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b abc=%0d nand=%h nor=%h cnt=%0d expected all 0",
               bus.busy, bus.abc, bus.table_nand, bus.table_nor,
               bus.mismatch_count);
    end
    np = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) np++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (np !== 0) begin
      errors++;
      $display("FAIL midrun_nodone: got %0d pulses expected 0", np);
    end
    rn = 8'h96;
    rr = 8'h96;
    run(-1, -1, lat, np, ab);
    checks++;
    if (lat !== EXP_LAT || np !== 1 || bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL midrun_rerun: got lat=%0d pulses=%0d pass=%b expected %0d/1/1",
               lat, np, bus.pass, EXP_LAT);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rn = 8'h00;
    rr = 8'h00;
    test_reset();
    test_run("equal", 8'h96, 8'h96);
    test_hold();
    test_run("single", 8'h96, 8'hB6);
    test_run("total", 8'h96, 8'h69);
    test_random();
    test_back_to_back();
    test_abort();
    test_start_abort_idle();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: wait cycles between applying a vector and sampling responses; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begin an exhaustive 8-vector run; sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  terminate an active run.
REQ-006 SHALL have port y_nand  input  1  response of the NAND-only implementation under test.
REQ-007 SHALL have port y_nor  input  1  response of the NOR-only implementation under test.
REQ-008 SHALL have port abc  output  3  stimulus vector {A,B,C}, with A as MSB.
REQ-009 SHALL have port busy  output  1  high while a run is active.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a run completes.
REQ-011 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-012 SHALL have port mismatch_count  output  4  number of vectors where y_nand != y_nor (0..8).
REQ-013 SHALL have port table_nand / table_nor  output  8 each  captured responses; bit i holds the response for abc==i.
REQ-014 SHALL have port first_fail  output  3  vector of the first mismatch.
REQ-015 SHALL have port fail_seen  output  1  high once any mismatch is captured in the current run.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-017 IDLE: start=1 and abort=0 -> APPLY; same cycle clears idx, mismatch_count, tables, first_fail, fail_seen and pass.
REQ-018 APPLY: drives abc=idx for one cycle -> SETTLE.
REQ-019 SETTLE: stays exactly SETTLE_CYCLES cycles -> SAMPLE.
REQ-020 SAMPLE: writes y_nand into table_nand[idx] and y_nor into table_nor[idx].
REQ-021 SAMPLE, on y_nand != y_nor: increments mismatch_count; if fail_seen==0, also latches first_fail=idx and sets fail_seen.
REQ-022 SAMPLE exit: idx==7 -> DONE; otherwise idx+1 -> APPLY.
REQ-023 DONE: done=1 for one cycle; pass = (mismatch_count==0) including the final sample; -> IDLE.
REQ-024 abc SHALL equal idx and stay stable across APPLY, SETTLE and SAMPLE; abc=0 in IDLE and DONE.
REQ-025 busy SHALL be 1 in APPLY, SETTLE, SAMPLE and DONE.
REQ-026 Latency: for start accepted at cycle t, done SHALL be high at cycle t+1+8*(SETTLE_CYCLES+2); this is cycle t+33 at the default.
REQ-027 start while busy SHALL be ignored.
REQ-028 start and abort asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-029 abort in any active state SHALL force IDLE next cycle with no done pulse and pass=0; partial tables, mismatch_count, first_fail and fail_seen are retained.
REQ-030 mismatch_count SHALL not wrap; its maximum is 8.
REQ-031 Results SHALL hold until the next accepted start.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE and set abc, busy, done, pass, mismatch_count, table_nand, table_nor, first_fail and fail_seen to 0, in any state including mid-run.
REQ-033 No done pulse SHALL be emitted for a run interrupted by reset.

Structure
REQ-034 Shared package de_seq_pkg SHALL hold: the state enum, VEC_W=3, NUM_VEC=8, CNT_W=4.
REQ-035 The settle counter SHALL be the sub-module settle_timer: load SETTLE_CYCLES, count down, expire flag.
REQ-036 The FSM SHALL be registered; outputs SHALL be registered or decoded from state only.

Verification
REQ-037 Equal responses: both responses driven as A^B^C, start pulse -> done at start+33, pass=1, mismatch_count=0, table_nand=table_nor=8'h96.
REQ-038 Single fault: y_nor inverted when abc==5 -> mismatch_count=1, first_fail=5, fail_seen=1, pass=0, table_nor=8'hB6.
REQ-039 Total fault: y_nor = ~y_nand for all vectors -> mismatch_count=8, first_fail=0, pass=0.
REQ-040 Abort: abort asserted while abc==3 -> busy=0 next cycle, no done pulse, pass=0, bits 3..7 of both tables =0.
REQ-041 Reset mid-run: rst_n=0 during SETTLE of vector 4 -> next cycle all outputs 0 and FSM in IDLE; a new start then completes in 33 cycles.
REQ-042 Start while busy: start re-pulsed at vector 2 -> run unaffected, single done pulse at start+33.
